// File: rtl/debug_unit.sv
// Host-link debug controller: program loader, run/step control
// and PC + register-file dump over a byte-wide serial link.
module debug_unit #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_write,
  output logic [NB_DATA-1:0] o_address,
  output logic [NB_DATA-1:0] o_instruction,
  output logic               o_enable,
  output logic [NB_REG-1:0]  o_address_read_debug,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic               i_halt
);

  localparam int BPW    = NB_DATA / NB_BYTE;
  localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NB_CNT-1:0] LAST = NB_CNT'(BPW - 1);

  localparam logic [NB_BYTE-1:0] CMD_LOAD = 'h4C;
  localparam logic [NB_BYTE-1:0] CMD_RUN  = 'h52;
  localparam logic [NB_BYTE-1:0] CMD_STEP = 'h53;
  localparam logic [NB_BYTE-1:0] CMD_DUMP = 'h44;

  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, RUN, STEP, DUMP_RD, DUMP_TX
  } state_t;

  state_t              state;
  logic [NB_DATA-1:0]  word;
  logic [NB_DATA-1:0]  load_addr;
  logic [NB_CNT-1:0]   cnt;
  logic                dump_pc;
  logic                rd_wait;

  logic               is_load, is_run, is_step, is_dump;
  logic [NB_DATA-1:0] next_word;

  assign is_load = i_rx_valid && (i_rx_data == CMD_LOAD);
  assign is_run  = i_rx_valid && (i_rx_data == CMD_RUN);
  assign is_step = i_rx_valid && (i_rx_data == CMD_STEP);
  assign is_dump = i_rx_valid && (i_rx_data == CMD_DUMP);

  assign next_word = {word[NB_DATA-NB_BYTE-1:0], i_rx_data};

  // The core must stop in the very cycle it reports HALT.
  assign o_enable = (state == RUN || state == STEP) && !i_halt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state                <= IDLE;
      word                 <= '0;
      load_addr            <= '0;
      cnt                  <= '0;
      dump_pc              <= 1'b0;
      rd_wait              <= 1'b0;
      o_tx_data            <= '0;
      o_tx_valid           <= 1'b0;
      o_write              <= 1'b0;
      o_address            <= '0;
      o_instruction        <= '0;
      o_address_read_debug <= '0;
    end else begin
      o_write <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            is_load: begin
              state     <= LOAD;
              load_addr <= '0;
              cnt       <= '0;
            end
            is_run:  state <= RUN;
            is_step: state <= STEP;
            is_dump: begin
              state                <= DUMP_TX;
              dump_pc              <= 1'b1;
              word                 <= i_pc;
              o_tx_data            <= i_pc[NB_DATA-1 -: NB_BYTE];
              o_tx_valid           <= 1'b1;
              cnt                  <= '0;
              o_address_read_debug <= '0;
            end
            default: ;
          endcase
        end
        LOAD: begin
          if (i_rx_valid) begin
            word <= next_word;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
              state         <= WRITE;
              o_write       <= 1'b1;
              o_address     <= load_addr;
              o_instruction <= next_word;
            end
          end
        end
        WRITE: begin
          load_addr <= load_addr + 1'b1;
          cnt       <= '0;
          state     <= (o_instruction == '0) ? IDLE : LOAD;
        end
        RUN: begin
          if (i_halt) state <= IDLE;
        end
        STEP: state <= IDLE;
        DUMP_RD: begin
          // Extra cycle covers a register file with registered read.
          if (!rd_wait) begin
            rd_wait <= 1'b1;
          end else begin
            rd_wait    <= 1'b0;
            word       <= i_data_read_debug;
            o_tx_data  <= i_data_read_debug[NB_DATA-1 -: NB_BYTE];
            o_tx_valid <= 1'b1;
            cnt        <= '0;
            state      <= DUMP_TX;
          end
        end
        DUMP_TX: begin
          if (i_tx_ready) begin
            if (cnt == LAST) begin
              o_tx_valid <= 1'b0;
              cnt        <= '0;
              dump_pc    <= 1'b0;
              if (dump_pc) begin
                o_address_read_debug <= '0;
                state                <= DUMP_RD;
              end else if (o_address_read_debug == '1) begin
                state <= IDLE;
              end else begin
                o_address_read_debug <= o_address_read_debug + 1'b1;
                state                <= DUMP_RD;
              end
            end else begin
              cnt       <= cnt + 1'b1;
              word      <= word << NB_BYTE;
              o_tx_data <= word[NB_DATA-NB_BYTE-1 -: NB_BYTE];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// Randomized bench for debug_unit: expected writes, enable pulses
// and dump streams are derived from the command protocol directly.
module tb_debug_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] pc;
  logic        halt;

  logic [31:0] regs [32];
  assign rd_data = regs[rd_addr];

  debug_unit dut (
    .i_clk                (clk),
    .i_reset              (rst_n),
    .i_rx_data            (rx_data),
    .i_rx_valid           (rx_valid),
    .i_tx_ready           (tx_ready),
    .o_tx_data            (tx_data),
    .o_tx_valid           (tx_valid),
    .o_write              (wr),
    .o_address            (addr),
    .o_instruction        (instr),
    .o_enable             (en),
    .o_address_read_debug (rd_addr),
    .i_data_read_debug    (rd_data),
    .i_pc                 (pc),
    .i_halt               (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  tx_q[$];
  int          en_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;

  always @(negedge clk) begin
    if (wr) begin
      wa_q.push_back(addr);
      wd_q.push_back(instr);
    end
    if (en) en_cnt++;
    if (prev_stall && rst_n)
      check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    prev_stall = rst_n && tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, {tx_data, tx_valid, wr, en, rd_addr}, 64'h0);
    check({tag, "_addr"}, addr, 64'h0);
    check({tag, "_instr"}, instr, 64'h0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_outs(tag);
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic do_load(input logic [31:0] prog[$], input bit junk);
    int e0;
    e0 = en_cnt;
    wa_q.delete();
    wd_q.delete();
    send_byte(8'h4C);
    foreach (prog[i]) begin
      for (int b = 3; b >= 0; b--) begin
        repeat ($urandom_range(0, 2)) tick();
        send_byte(prog[i][8*b +: 8]);
      end
      if (junk && $urandom_range(0, 1) == 1)
        send_byte(8'($urandom_range(0, 255)));
      else
        tick();
    end
    send_byte(8'h41);
    repeat (3) tick();
    check("load_n", wa_q.size(), prog.size());
    foreach (prog[i]) begin
      if (i < wa_q.size()) begin
        check("load_addr", wa_q[i], i);
        check("load_data", wd_q[i], prog[i]);
      end
    end
    check("load_en", en_cnt - e0, 0);
  endtask

  task automatic do_run(input int k);
    int e0;
    int w0;
    e0 = en_cnt;
    w0 = wa_q.size();
    halt = 1'b0;
    send_byte(8'h52);
    rx_data  = 8'h4C;
    rx_valid = 1'b1;
    repeat (k) tick();
    rx_valid = 1'b0;
    halt = 1'b1;
    repeat (3) tick();
    check("run_en", en_cnt - e0, k);
    check("run_nowr", wa_q.size(), w0);
  endtask

  task automatic do_step(input logic h);
    int e0;
    halt = h;
    e0 = en_cnt;
    send_byte(8'h53);
    repeat (3) tick();
    check(h ? "step_halt" : "step", en_cnt - e0, h ? 0 : 1);
  endtask

  task automatic do_dump(input logic [31:0] p, input bit rnd);
    logic [7:0] exp[$];
    int n;
    int e0;
    for (int b = 3; b >= 0; b--) exp.push_back(p[8*b +: 8]);
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--) exp.push_back(regs[r][8*b +: 8]);
    tx_q.delete();
    wa_q.delete();
    wd_q.delete();
    e0 = en_cnt;
    halt = 1'b0;
    pc = p;
    tx_ready = 1'b1;
    send_byte(8'h44);
    pc = ~p;
    rx_data = 8'h4C;
    n = 0;
    while (tx_q.size() < 132 && n < 3000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : ~tx_ready;
      rx_valid = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) tick();
    check("dump_len", tx_q.size(), 132);
    check("dump_vld", tx_valid, 1'b0);
    foreach (exp[i]) begin
      if (i < tx_q.size()) check("dump_byte", {i, tx_q[i]}, {i, exp[i]});
    end
    check("dump_en", en_cnt - e0, 0);
    check("dump_nowr", wa_q.size(), 0);
  endtask

  logic [31:0] prog[$];
  int          nb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    pc       = '0;
    halt     = 1'b0;
    foreach (regs[i]) regs[i] = '0;
    #3 check_reset_outs("reset");
    #10 rst_n = 1'b1;
    tick();

    prog = '{32'h0022_1820, 32'h0};
    do_load(prog, 1'b0);
    for (int t = 0; t < 3; t++) begin
      prog.delete();
      repeat ($urandom_range(1, 5)) begin
        logic [31:0] w;
        w = $urandom;
        if (w == 0) w = 32'h1;
        prog.push_back(w);
      end
      prog.push_back(32'h0);
      do_load(prog, 1'b1);
    end

    do_run(5);
    for (int t = 0; t < 2; t++) do_run($urandom_range(1, 10));
    do_step(1'b1);
    do_step(1'b0);
    do_step(1'b0);

    regs[3] = 32'hF;
    do_dump(32'h4, 1'b0);
    foreach (regs[i]) regs[i] = $urandom;
    do_dump($urandom, 1'b1);

    wa_q.delete();
    wd_q.delete();
    send_byte(8'h4C);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_reset("rst_load");
    send_byte(8'h4C);
    send_word(32'h1122_3344);
    repeat (3) tick();
    check("rl_n", wa_q.size(), 1);
    if (wa_q.size() > 0) begin
      check("rl_addr", wa_q[0], 0);
      check("rl_data", wd_q[0], 32'h1122_3344);
    end
    send_word(32'h0);
    repeat (3) tick();
    check("rl_n2", wa_q.size(), 2);
    if (wa_q.size() > 1) check("rl_addr2", wa_q[1], 1);

    tx_ready = 1'b1;
    send_byte(8'h44);
    repeat (20) tick();
    wa_q.delete();
    pulse_reset("rst_dump");
    nb = tx_q.size();
    repeat (8) tick();
    check("rd_notx", tx_q.size(), nb);
    check("rd_vld", tx_valid, 1'b0);
    check("rd_nowr", wa_q.size(), 0);
    do_step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
